// File: rtl/rom_rd_pkg.sv
// rtl/rom_rd_pkg.sv - shared types and constants for the ROM read-stream engine
package rom_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = 2;

endpackage

// File: rtl/rom_rd_fifo.sv
// rtl/rom_rd_fifo.sv - 2-entry synchronous FIFO of {last, data} with occupancy count
module rom_rd_fifo
  import rom_rd_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [DW-1:0]      i_data,
  output logic [DW-1:0]      o_data,
  output logic [FIFO_CW-1:0] o_count
);

  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [FIFO_CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + FIFO_CW'(i_push) - FIFO_CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rom_sp.sv
// rtl/rom_sp.sv - single-port ROM whose word at address a is INIT_BASE + a
module rom_sp #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int OUT_REG   = 1,
  parameter int INIT_BASE = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;

  assign w_word = WIDTH'(INIT_BASE) + WIDTH'(rd_addr_i);

  always_ff @(posedge clk_i) begin
    if (rd_en_i) r_data <= w_word;
  end

  // Combinational flavour shows the addressed word while enabled, else the last word read.
  assign rd_data_o = (OUT_REG != 0) ? r_data : (rd_en_i ? w_word : r_data);

endmodule

// File: rtl/rom_rd_stream.sv
// rtl/rom_rd_stream.sv - walks a wrap-around ROM address range and streams words with backpressure
module rom_rd_stream
  import rom_rd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int OUT_REG = 1,
  parameter int AW      = $clog2(DEPTH),
  parameter int LW      = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    base_i,
  input  logic [LW-1:0]    len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rom_rd_en_o,
  output logic [AW-1:0]    rom_rd_addr_o,
  input  logic [WIDTH-1:0] rom_rd_data_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i
);

  state_t             r_state;
  logic [AW-1:0]      r_addr;
  logic [LW-1:0]      r_len;
  logic [LW-1:0]      r_issued;
  logic               r_busy;
  logic               r_done;

  logic               w_pop;
  logic               w_rd_en;
  logic               w_last_issue;
  logic               w_push;
  logic               w_push_last;
  logic               w_inflight;
  logic [FIFO_CW-1:0] w_count;
  logic [2:0]         w_credit;
  logic [WIDTH:0]     w_fifo_out;
  logic [AW-1:0]      w_addr_next;

  assign m_valid_o    = (w_count != '0);
  assign w_pop        = m_valid_o & m_ready_i;
  assign w_last_issue = (r_issued == r_len - LW'(1));

  // Occupancy the FIFO will have once everything in flight lands, net of this cycle's pop.
  assign w_credit = 3'(w_count) + 3'(w_inflight) - 3'(w_pop);
  assign w_rd_en  = (r_state == ST_ISSUE) && (w_credit < 3'(FIFO_DEPTH));

  assign w_addr_next = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic r_infl;
      logic r_infl_last;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_infl      <= 1'b0;
          r_infl_last <= 1'b0;
        end else begin
          r_infl      <= w_rd_en;
          r_infl_last <= w_rd_en & w_last_issue;
        end
      end

      assign w_inflight  = r_infl;
      assign w_push      = r_infl;
      assign w_push_last = r_infl_last;
    end else begin : g_comb
      assign w_inflight  = 1'b0;
      assign w_push      = w_rd_en;
      assign w_push_last = w_last_issue;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_addr   <= base_i;
            r_len    <= len_i;
            r_issued <= '0;
            if (len_i != '0) begin
              r_state <= ST_ISSUE;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_rd_en) begin
            r_addr   <= w_addr_next;
            r_issued <= r_issued + LW'(1);
            if (w_last_issue) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && m_last_o) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rom_rd_fifo #(
    .DW(WIDTH + 1)
  ) u_fifo (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data ({w_push_last, rom_rd_data_i}),
    .o_data (w_fifo_out),
    .o_count(w_count)
  );

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign rom_rd_en_o   = w_rd_en;
  assign rom_rd_addr_o = r_addr;
  assign m_data_o      = w_fifo_out[WIDTH-1:0];
  assign m_last_o      = w_fifo_out[WIDTH];

endmodule

// File: tb/tb_rom_rd_stream.sv
// tb/tb_rom_rd_stream.sv - directed checks of rom_rd_stream with registered and combinational ROMs
module tb_rom_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready;
  logic [2:0] base;
  logic [3:0] len;

  logic       a_busy, a_done, a_rden, a_valid, a_last;
  logic [2:0] a_addr;
  logic [7:0] a_rdata, a_data;
  logic       b_busy, b_done, b_rden, b_valid, b_last;
  logic [2:0] b_addr;
  logic [7:0] b_rdata, b_data;

  always #5 clk = ~clk;

  rom_sp #(.WIDTH(8), .DEPTH(8), .OUT_REG(1), .INIT_BASE(16)) rom_a (
    .clk_i(clk), .rd_en_i(a_rden), .rd_addr_i(a_addr), .rd_data_o(a_rdata));

  rom_rd_stream #(.WIDTH(8), .DEPTH(8), .OUT_REG(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
    .busy_o(a_busy), .done_o(a_done), .rom_rd_en_o(a_rden), .rom_rd_addr_o(a_addr),
    .rom_rd_data_i(a_rdata), .m_data_o(a_data), .m_valid_o(a_valid), .m_last_o(a_last),
    .m_ready_i(ready));

  rom_sp #(.WIDTH(8), .DEPTH(8), .OUT_REG(0), .INIT_BASE(16)) rom_b (
    .clk_i(clk), .rd_en_i(b_rden), .rd_addr_i(b_addr), .rd_data_o(b_rdata));

  rom_rd_stream #(.WIDTH(8), .DEPTH(8), .OUT_REG(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .len_i(len),
    .busy_o(b_busy), .done_o(b_done), .rom_rd_en_o(b_rden), .rom_rd_addr_o(b_addr),
    .rom_rd_data_i(b_rdata), .m_data_o(b_data), .m_valid_o(b_valid), .m_last_o(b_last),
    .m_ready_i(ready));

  typedef struct {
    logic       start;
    logic       a_rden;
    logic [2:0] a_addr;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_done;
    logic       a_busy;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_done;
  } vec_t;

  vec_t vecs[12];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] q_words[$];
  logic       q_lasts[$];
  logic [2:0] q_addrs[$];
  int done_cyc, busy_at_done, stall_err, credit_err, fifo_err, valid_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Runs one command on the OUT_REG=1 engine and records what the stream and ROM port did.
  task automatic run_cmd(input logic [2:0] b, input logic [3:0] l, input logic [7:0] pat,
                         input int budget);
    int         outstanding;
    logic       pop;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    q_words.delete(); q_lasts.delete(); q_addrs.delete();
    done_cyc = -1; busy_at_done = -1; stall_err = 0; credit_err = 0; fifo_err = 0;
    valid_seen = 0; outstanding = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = (c == 0);
      base  = b;
      len   = l;
      ready = pat[c % 8];
      #1;
      if (prev_stall && (!a_valid || a_data !== prev_data || a_last !== prev_last)) stall_err++;
      pop = a_valid & ready;
      if (a_valid) valid_seen++;
      if (a_rden) begin
        q_addrs.push_back(a_addr);
        if (outstanding - int'(pop) >= 2) credit_err++;
      end
      if (pop) begin
        q_words.push_back(a_data);
        q_lasts.push_back(a_last);
      end
      if (dut_a.u_fifo.o_count > 2) fifo_err++;
      outstanding = outstanding + int'(a_rden) - int'(pop);
      prev_stall = a_valid & ~ready;
      prev_data  = a_data;
      prev_last  = a_last;
      if (a_done) begin
        done_cyc     = c;
        busy_at_done = int'(a_busy);
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] bp_pat;
    rst = 1'b0; start = 1'b0; ready = 1'b0; base = '0; len = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    chk("reset rden", a_rden, 0);
    chk("reset valid", a_valid, 0);
    chk("reset last", a_last, 0);
    chk("reset addr", a_addr, 0);
    chk("reset data", a_data, 0);
    chk("reset b valid", b_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full sweep, base 0 len 8, ready held high; A has OUT_REG=1, B has OUT_REG=0.
    for (int c = 0; c < 12; c++) begin
      vecs[c].start   = (c == 0);
      vecs[c].a_rden  = (c >= 1 && c <= 8);
      vecs[c].a_addr  = 3'(c - 1);
      vecs[c].a_valid = (c >= 3 && c <= 10);
      vecs[c].a_data  = 8'(16 + c - 3);
      vecs[c].a_last  = (c == 10);
      vecs[c].a_done  = (c == 11);
      vecs[c].a_busy  = (c >= 1 && c <= 10);
      vecs[c].b_valid = (c >= 2 && c <= 9);
      vecs[c].b_data  = 8'(16 + c - 2);
      vecs[c].b_last  = (c == 9);
      vecs[c].b_done  = (c == 10);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = vecs[c].start; base = 3'd0; len = 4'd8; ready = 1'b1;
      #1;
      chk($sformatf("sweep c%0d rden", c), a_rden, vecs[c].a_rden);
      if (vecs[c].a_rden) chk($sformatf("sweep c%0d addr", c), a_addr, vecs[c].a_addr);
      chk($sformatf("sweep c%0d valid", c), a_valid, vecs[c].a_valid);
      if (vecs[c].a_valid) begin
        chk($sformatf("sweep c%0d data", c), a_data, vecs[c].a_data);
        chk($sformatf("sweep c%0d last", c), a_last, vecs[c].a_last);
      end
      chk($sformatf("sweep c%0d done", c), a_done, vecs[c].a_done);
      chk($sformatf("sweep c%0d busy", c), a_busy, vecs[c].a_busy);
      chk($sformatf("sweep0 c%0d valid", c), b_valid, vecs[c].b_valid);
      if (vecs[c].b_valid) begin
        chk($sformatf("sweep0 c%0d data", c), b_data, vecs[c].b_data);
        chk($sformatf("sweep0 c%0d last", c), b_last, vecs[c].b_last);
      end
      chk($sformatf("sweep0 c%0d done", c), b_done, vecs[c].b_done);
    end
    start = 1'b0;

    // Wrap-around: base 6, len 4.
    run_cmd(3'd6, 4'd4, 8'hFF, 30);
    chk("wrap done cycle", done_cyc, 7);
    chk("wrap addr count", q_addrs.size(), 4);
    chk("wrap word count", q_words.size(), 4);
    if (q_addrs.size() == 4) begin
      chk("wrap addr0", q_addrs[0], 6);
      chk("wrap addr1", q_addrs[1], 7);
      chk("wrap addr2", q_addrs[2], 0);
      chk("wrap addr3", q_addrs[3], 1);
    end
    if (q_words.size() == 4) begin
      chk("wrap word0", q_words[0], 8'h16);
      chk("wrap word1", q_words[1], 8'h17);
      chk("wrap word2", q_words[2], 8'h10);
      chk("wrap word3", q_words[3], 8'h11);
      chk("wrap lasts", {q_lasts[0], q_lasts[1], q_lasts[2], q_lasts[3]}, 4'b0001);
    end

    // Backpressure: ready pattern 1,0,0,0,0,1,0,1 repeating.
    bp_pat = 8'b1010_0001;
    run_cmd(3'd0, 4'd8, bp_pat, 150);
    chk("bp done seen", done_cyc >= 0, 1);
    chk("bp busy at done", busy_at_done, 0);
    chk("bp word count", q_words.size(), 8);
    chk("bp stall stability", stall_err, 0);
    chk("bp credit rule", credit_err, 0);
    chk("bp fifo bound", fifo_err, 0);
    for (int i = 0; i < q_words.size() && i < 8; i++) begin
      chk($sformatf("bp word%0d", i), q_words[i], 8'(16 + i));
      chk($sformatf("bp last%0d", i), q_lasts[i], (i == 7));
    end

    // Zero length.
    run_cmd(3'd3, 4'd0, 8'hFF, 6);
    chk("zero done cycle", done_cyc, 1);
    chk("zero busy at done", busy_at_done, 0);
    chk("zero reads", q_addrs.size(), 0);
    chk("zero valid", valid_seen, 0);

    // Start while busy is ignored, then reset aborts after the third word.
    q_words.delete();
    done_cyc = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 4);
      base  = (c == 4) ? 3'd4 : 3'd0;
      len   = (c == 4) ? 4'd2 : 4'd8;
      ready = 1'b1;
      #1;
      if (a_valid) q_words.push_back(a_data);
      if (a_done) done_cyc = c;
    end
    @(negedge clk);
    start = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort word count", q_words.size(), 3);
    if (q_words.size() == 3) begin
      chk("abort word0", q_words[0], 8'h10);
      chk("abort word1", q_words[1], 8'h11);
      chk("abort word2 ignores busy start", q_words[2], 8'h12);
    end
    chk("abort no early done", done_cyc, -1);
    chk("abort async busy", a_busy, 0);
    chk("abort async rden", a_rden, 0);
    chk("abort async valid", a_valid, 0);
    chk("abort async last", a_last, 0);
    chk("abort async addr", a_addr, 0);
    chk("abort async data", a_data, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort hold c%0d done", c), a_done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort release done", a_done, 0);

    run_cmd(3'd2, 4'd2, 8'hFF, 20);
    chk("post reset done seen", done_cyc >= 0, 1);
    chk("post reset word count", q_words.size(), 2);
    if (q_words.size() == 2) begin
      chk("post reset word0", q_words[0], 8'h12);
      chk("post reset word1", q_words[1], 8'h13);
      chk("post reset lasts", {q_lasts[0], q_lasts[1]}, 2'b01);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
